apb_mem_slave: RTL and testbench
================================

Name: apb_mem_slave

Overview:
Parametrised APB4-compliant memory slave. It is the next generation of our fixed 32-bit/256-word APB RAM slave. It adds proper PENABLE-based setup/access phasing, configurable wait states, PSTRB byte-lane writes and PSLVERR for out-of-range accesses. It sits behind the APB bridge as a scratch/config memory and as the reference target for bridge verification.

Parameters:
DATA_WIDTH, 32, data bus width in bits; legal values 8/16/32/64.
ADDR_WIDTH, 12, PADDR width; PADDR is a byte address.
DEPTH, 256, number of DATA_WIDTH words implemented; must be ≤ 2**(ADDR_WIDTH-BYTE_OFF).
WAIT_STATES, 0, access-phase cycles with PREADY low before completion; legal range 0..15.

Ports:
PCLK  in  1  APB clock; all logic on rising edge.
PRESETn  in  1  reset, asynchronous, active-low.
PSEL  in  1  slave select.
PENABLE  in  1  access-phase indicator.
PWRITE  in  1  1 = write, 0 = read.
PADDR  in  ADDR_WIDTH  byte address.
PWDATA  in  DATA_WIDTH  write data.
PSTRB  in  DATA_WIDTH/8  write byte strobes; bit i enables PWDATA[8i+7:8i].
PRDATA  out  DATA_WIDTH  read data; valid only while PREADY=1.
PREADY  out  1  transfer completion, registered.
PSLVERR  out  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (PRESETn=0, async): PRDATA=0, PREADY=0, PSLVERR=0, state=IDLE, wait counter=0. Memory contents are neither cleared nor written.
- Word index = PADDR[ADDR_WIDTH-1:BYTE_OFF], where BYTE_OFF = log2(DATA_WIDTH/8). Low BYTE_OFF address bits are ignored; no alignment error.
- Out of range: index ≥ DEPTH. Sets PSLVERR=1 on the completing cycle. No memory write. PRDATA=0.
- FSM states: IDLE, ACCESS.
- IDLE:
  - Setup phase is sampled as PSEL=1, PENABLE=0. On it: go to ACCESS, load counter=WAIT_STATES.
  - If WAIT_STATES=0, also register PREADY=1 with the response (see completion).
  - PSEL=1 and PENABLE=1 while in IDLE is a protocol error: ignore it, stay in IDLE, no response.
- ACCESS:
  - PREADY low while counter>0. Each cycle with PSEL=1 and PENABLE=1 decrements counter.
  - The edge where counter goes 1→0 registers PREADY=1 with the response.
- Completion cycle:
  - PREADY=1 for exactly one cycle. The transfer completes at that cycle's end: first access cycle + WAIT_STATES.
  - Write: on the edge that sets PREADY, bytes with PSTRB[i]=1 are written to mem[index]; other bytes are unchanged. PSTRB=0 is a legal no-op write with OKAY response.
  - Read: PRDATA is loaded from mem[index] on the edge that sets PREADY. PSTRB is ignored.
  - Next edge: PREADY←0, PRDATA←0, PSLVERR←0, state←IDLE.
- Back-to-back: a new setup phase in the cycle after PREADY=1 is accepted. Maximum throughput is one transfer per 2+WAIT_STATES cycles.
- Abort: PSEL=0 while in ACCESS with PREADY=0 → return to IDLE. No write, no response.
- Address, write data, strobes and direction are those presented during the access phase. Masters hold them stable per APB; the slave does not re-check this.
- Read-after-write to the same address in the next transfer returns the new data (no bypass needed, since the write commits before the read samples).
- Reset asserted mid-transfer: outputs go to 0 immediately. A write whose PREADY edge has not occurred is lost.

Decomposition:
- Shared package apb_pkg:
  - State enum {IDLE, ACCESS}.
  - Functions for STRB_W = DATA_WIDTH/8 and BYTE_OFF.
  - Constants APB_OKAY=0, APB_ERROR=1.
  - WAIT_CNT_W = 4.
- One sub-module: apb_byte_ram, a synchronous single-port RAM.
  - Ports: clk, we, be[STRB_W], addr, wdata, rdata.
  - Per-byte write enables; registered read.
  - The top block owns the FSM, counter, range check and response registers.

Test Plan:
- Reset/idle: PRESETn low for 3 cycles, then PSEL=0 → PREADY=0, PSLVERR=0, PRDATA=0 throughout.
- Zero-wait write/read (WAIT_STATES=0): write 0xDEADBEEF to 0x010 with PSTRB=0xF, then read 0x010 → each transfer completes on the first access cycle; PRDATA=0xDEADBEEF; PSLVERR=0.
- Byte strobes: preload 0x11223344 at 0x020, write 0xAABBCCDD with PSTRB=0x5, then read → PRDATA=0x11BB33DD.
- Wait states (WAIT_STATES=3): read 0x010 → PREADY low for 3 access cycles, high on the 4th, one cycle wide, with correct data.
- Range error (DEPTH=256, DATA_WIDTH=32): write 0x5A5A5A5A to byte address 0x400 → PREADY=1 with PSLVERR=1. A read of 0x000 is unchanged. A read of 0x400 returns PSLVERR=1, PRDATA=0.
- Abort/reset mid-op (WAIT_STATES=3): drop PSEL after 1 access cycle of a write to 0x030 → no PREADY, memory unchanged. Repeat with PRESETn pulsed low in cycle 2 → outputs 0 immediately; the next transfer works normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer state, response codes and bus-geometry helpers.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int   WAIT_CNT_W = 4;
    localparam logic APB_OKAY   = 1'b0;
    localparam logic APB_ERROR  = 1'b1;

    function automatic int strb_w(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int byte_off(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_byte_ram.sv
// Synchronous single-port RAM with per-byte write enables and a registered read port.
module apb_byte_ram
    import apb_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 256,
    localparam int STRB_W     = strb_w(DATA_WIDTH),
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [STRB_W-1:0]     be,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read-first: a write and a read in the same cycle return the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 memory slave: setup/access phasing, programmable wait states, byte strobes, range error.
//   state  | meaning
//   IDLE   | no transfer in progress, waiting for a setup phase
//   ACCESS | access phase; PREADY low while the wait counter is non-zero
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_WIDTH-1:0]        PADDR,
    input  logic [DATA_WIDTH-1:0]        PWDATA,
    input  logic [strb_w(DATA_WIDTH)-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]        PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR
);

    localparam int STRB_W   = strb_w(DATA_WIDTH);
    localparam int BYTE_OFF = byte_off(DATA_WIDTH);
    localparam int IDX_W    = ADDR_WIDTH - BYTE_OFF;
    localparam int RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

    apb_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic                  rd_ok_q, rd_ok_d;

    logic [IDX_W-1:0]      word_idx;
    logic                  in_range;
    logic                  complete;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  unused_paddr;

    assign word_idx     = PADDR[ADDR_WIDTH-1:BYTE_OFF];
    assign in_range     = (32'(word_idx) < DEPTH);
    assign unused_paddr = ^PADDR;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = APB_OKAY;
        rd_ok_d   = 1'b0;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d  = ACCESS;
                    cnt_d    = WAIT_INIT;
                    complete = (WAIT_INIT == '0);
                end
            end
            ACCESS: begin
                if (pready_q || !PSEL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (PENABLE && (cnt_q != '0)) begin
                    cnt_d    = cnt_q - WAIT_CNT_W'(1);
                    complete = (cnt_q == WAIT_CNT_W'(1));
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (complete) begin
            pready_d  = 1'b1;
            pslverr_d = in_range ? APB_OKAY : APB_ERROR;
            rd_ok_d   = !PWRITE && in_range;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= APB_OKAY;
            rd_ok_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            rd_ok_q   <= rd_ok_d;
        end
    end

    assign ram_we = complete && PWRITE && in_range;

    apb_byte_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (PCLK),
        .we    (ram_we),
        .be    (PSTRB),
        .addr  (word_idx[RAM_AW-1:0]),
        .wdata (PWDATA),
        .rdata (ram_rdata)
    );

    // RAM read data is only exposed on an in-range read completion; zero otherwise.
    assign PRDATA  = rd_ok_q ? ram_rdata : '0;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: one zero-wait and one three-wait instance against a transfer-level model.
module tb_apb_mem_slave;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int DEPTH = 256;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;

    logic            psel    [2];
    logic            penable [2];
    logic            pwrite  [2];
    logic [AW-1:0]   paddr   [2];
    logic [DW-1:0]   pwdata  [2];
    logic [3:0]      pstrb   [2];
    logic [DW-1:0]   prdata  [2];
    logic            pready  [2];
    logic            pslverr [2];

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, i, act, exp, $time);
        end
    endtask

    // Transfer-level model: a transfer completes on access cycle number (wait states + 1).
    bit [31:0] mem_m   [2][DEPTH];
    bit        known_m [2][DEPTH];
    bit        busy_m  [2];
    int        k_m     [2];

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    always @(negedge PCLK) begin
        for (int i = 0; i < 2; i++) begin
            bit          exp_rdy;
            bit          exp_err;
            bit          chk_dat;
            logic [31:0] exp_dat;
            int          idx;
            exp_rdy = 1'b0;
            exp_err = 1'b0;
            chk_dat = 1'b1;
            exp_dat = '0;
            idx     = 0;
            if (!PRESETn || !psel[i]) begin
                busy_m[i] = 1'b0;
            end else if (!penable[i]) begin
                busy_m[i] = 1'b1;
                k_m[i]    = 0;
            end else if (busy_m[i]) begin
                k_m[i]++;
                if (k_m[i] == ws_of(i) + 1) begin
                    idx     = int'(paddr[i]) / 4;
                    exp_rdy = 1'b1;
                    exp_err = (idx >= DEPTH);
                    if (pwrite[i]) begin
                        chk_dat = 1'b0;
                        if (!exp_err) begin
                            for (int b = 0; b < 4; b++)
                                if (pstrb[i][b]) mem_m[i][idx][8*b +: 8] = pwdata[i][8*b +: 8];
                            if (pstrb[i] == 4'hF) known_m[i][idx] = 1'b1;
                        end
                    end else if (!exp_err) begin
                        if (known_m[i][idx]) exp_dat = mem_m[i][idx];
                        else chk_dat = 1'b0;
                    end
                    busy_m[i] = 1'b0;
                end
            end
            chk("PREADY", i, 32'(pready[i]), 32'(exp_rdy));
            chk("PSLVERR", i, 32'(pslverr[i]), 32'(exp_err));
            if (chk_dat) chk("PRDATA", i, prdata[i], exp_dat);
        end
    end

    task automatic xfer(input int i, input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic err, output int lat);
        bit done;
        done = 1'b0;
        rd   = '0;
        err  = 1'b0;
        lat  = 0;
        @(posedge PCLK); #1;
        psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = wr;
        paddr[i] = a; pwdata[i] = wd; pstrb[i] = st;
        @(posedge PCLK); #1;
        penable[i] = 1'b1;
        for (int n = 1; n <= 40 && !done; n++) begin
            @(negedge PCLK);
            if (pready[i] === 1'b1) begin
                done = 1'b1;
                lat  = n;
                rd   = prdata[i];
                err  = pslverr[i];
            end else if (n < 40) begin
                @(posedge PCLK); #1;
            end
        end
        if (!done) chk("pready_timeout", i, 32'd0, 32'd1);
    endtask

    task automatic idle(input int i, input int n);
        @(posedge PCLK); #1;
        psel[i] = 1'b0; penable[i] = 1'b0;
        repeat (n - 1) @(posedge PCLK);
    endtask

    task automatic abort_write(input int i, input logic [AW-1:0] a, input logic [31:0] wd, input bit by_reset);
        @(posedge PCLK); #1;
        psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = 1'b1;
        paddr[i] = a; pwdata[i] = wd; pstrb[i] = 4'hF;
        @(posedge PCLK); #1;
        penable[i] = 1'b1;
        @(posedge PCLK); #1;
        if (by_reset) begin
            PRESETn = 1'b0;
            #1;
            chk("rst_mid_pready", i, 32'(pready[i]), 32'd0);
            chk("rst_mid_pslverr", i, 32'(pslverr[i]), 32'd0);
            chk("rst_mid_prdata", i, prdata[i], 32'd0);
            @(posedge PCLK); #1;
            PRESETn = 1'b1;
        end
        psel[i] = 1'b0; penable[i] = 1'b0;
        repeat (2) @(posedge PCLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0;
        end
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset_pready", 0, 32'(pready[0]), 32'd0);
        chk("reset_prdata", 1, prdata[1], 32'd0);
        PRESETn = 1'b1;
        repeat (2) @(posedge PCLK);

        // zero-wait write then back-to-back read
        xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, rd, err, lat);
        chk("zw_write_lat", 0, 32'(lat), 32'd1);
        chk("zw_write_err", 0, 32'(err), 32'd0);
        xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, err, lat);
        chk("zw_read_data", 0, rd, 32'hDEADBEEF);
        chk("zw_read_lat", 0, 32'(lat), 32'd1);
        xfer(0, 1'b0, 12'h013, 32'h0, 4'h0, rd, err, lat);
        chk("unaligned_read", 0, rd, 32'hDEADBEEF);

        // byte strobes, then a no-op strobe write
        xfer(0, 1'b1, 12'h020, 32'h11223344, 4'hF, rd, err, lat);
        xfer(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'h5, rd, err, lat);
        xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, rd, err, lat);
        chk("strobe_read", 0, rd, 32'h11BB33DD);
        xfer(0, 1'b1, 12'h020, 32'hFFFFFFFF, 4'h0, rd, err, lat);
        chk("nostrb_err", 0, 32'(err), 32'd0);
        xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, rd, err, lat);
        chk("nostrb_read", 0, rd, 32'h11BB33DD);

        // range boundary and error
        xfer(0, 1'b1, 12'h000, 32'h01234567, 4'hF, rd, err, lat);
        xfer(0, 1'b1, 12'h3FC, 32'h89ABCDEF, 4'hF, rd, err, lat);
        chk("last_word_err", 0, 32'(err), 32'd0);
        xfer(0, 1'b1, 12'h400, 32'h5A5A5A5A, 4'hF, rd, err, lat);
        chk("oor_write_err", 0, 32'(err), 32'd1);
        xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, rd, err, lat);
        chk("word0_unchanged", 0, rd, 32'h01234567);
        xfer(0, 1'b0, 12'h400, 32'h0, 4'h0, rd, err, lat);
        chk("oor_read_err", 0, 32'(err), 32'd1);
        chk("oor_read_data", 0, rd, 32'h0);
        xfer(0, 1'b0, 12'h3FC, 32'h0, 4'h0, rd, err, lat);
        chk("last_word_read", 0, rd, 32'h89ABCDEF);
        idle(0, 2);

        // stray access phase with no setup is ignored
        @(posedge PCLK); #1;
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 12'h000; pwdata[0] = 32'h0;
        repeat (2) @(posedge PCLK);
        idle(0, 2);

        // wait states
        xfer(1, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, rd, err, lat);
        chk("ws_write_lat", 1, 32'(lat), 32'd4);
        xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, rd, err, lat);
        chk("ws_read_lat", 1, 32'(lat), 32'd4);
        chk("ws_read_data", 1, rd, 32'hDEADBEEF);
        idle(1, 1);
        #1;
        chk("ws_one_cycle", 1, 32'(pready[1]), 32'd0);

        // abort and reset mid-transfer
        xfer(1, 1'b1, 12'h030, 32'hCAFEF00D, 4'hF, rd, err, lat);
        idle(1, 1);
        abort_write(1, 12'h030, 32'h55555555, 1'b0);
        xfer(1, 1'b0, 12'h030, 32'h0, 4'h0, rd, err, lat);
        chk("abort_read", 1, rd, 32'hCAFEF00D);
        idle(1, 1);
        abort_write(1, 12'h030, 32'h77777777, 1'b1);
        xfer(1, 1'b0, 12'h030, 32'h0, 4'h0, rd, err, lat);
        chk("post_reset_read", 1, rd, 32'hCAFEF00D);
        chk("post_reset_lat", 1, 32'(lat), 32'd4);
        xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, rd, err, lat);
        chk("post_reset_b2b", 1, rd, 32'hDEADBEEF);
        idle(1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
